// File: rtl/fv_commit_tracker.sv
// In-order issue/commit tracking buffer for the formal harness.
// Records IF->EX issues and presents each committed entry one cycle after commit.
module fv_commit_tracker #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned SEQ_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic                         issue_valid,
    input  logic [ADDR_W-1:0]            issue_pc,
    input  logic [INSTR_W-1:0]           issue_instr,
    input  logic                         issue_stall,
    input  logic                         kill,
    input  logic                         commit,
    output logic                         ret_valid,
    output logic [ADDR_W-1:0]            ret_pc,
    output logic [INSTR_W-1:0]           ret_instr,
    output logic [SEQ_W-1:0]             ret_seq,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         err_overflow,
    output logic                         err_underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    // Entry storage; contents are don't-care after reset, so no reset here.
    logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];
    logic [INSTR_W-1:0] r_mem_instr [DEPTH];
    logic [SEQ_W-1:0]   r_mem_seq   [DEPTH];

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [SEQ_W-1:0]   r_seq_cnt;
    logic               r_empty;
    logic               r_full;
    logic               r_err_overflow;
    logic               r_err_underflow;
    logic               r_ret_valid;
    logic [ADDR_W-1:0]  r_ret_pc;
    logic [INSTR_W-1:0] r_ret_instr;
    logic [SEQ_W-1:0]   r_ret_seq;

    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_overflow;
    logic               w_underflow;
    logic [PTR_W-1:0]   w_rd_ptr_nxt;
    logic [PTR_W-1:0]   w_wr_ptr_nxt;
    logic [CNT_W-1:0]   w_count_nxt;

    // A push into a full buffer is only accepted when a pop frees a slot the same cycle.
    assign w_push_req  = issue_valid & ~issue_stall & ~kill;
    assign w_pop       = commit & ~r_empty;
    assign w_push      = w_push_req & (~r_full | w_pop);
    assign w_overflow  = w_push_req & r_full & ~commit;
    assign w_underflow = commit & r_empty;

    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        end
    end

    // Kill drops everything left after a same-cycle pop.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        if (kill) begin
            w_wr_ptr_nxt = w_rd_ptr_nxt;
        end else if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (kill) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= issue_pc;
            r_mem_instr[r_wr_ptr] <= issue_instr;
            r_mem_seq[r_wr_ptr]   <= r_seq_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_seq_cnt       <= '0;
            r_empty         <= 1'b1;
            r_full          <= 1'b0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_count   <= w_count_nxt;
            r_empty   <= (w_count_nxt == '0);
            r_full    <= (w_count_nxt == CNT_W'(DEPTH));
            // Tag is never rewound on kill so post-flush tags stay unique.
            if (w_push) begin
                r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
            end
            if (w_overflow) begin
                r_err_overflow <= 1'b1;
            end
            if (w_underflow) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    // Retire port: fields hold their last value when nothing pops.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_ret_valid <= 1'b0;
            r_ret_pc    <= '0;
            r_ret_instr <= '0;
            r_ret_seq   <= '0;
        end else begin
            r_ret_valid <= w_pop;
            if (w_pop) begin
                r_ret_pc    <= r_mem_pc[r_rd_ptr];
                r_ret_instr <= r_mem_instr[r_rd_ptr];
                r_ret_seq   <= r_mem_seq[r_rd_ptr];
            end
        end
    end

    assign ret_valid     = r_ret_valid;
    assign ret_pc        = r_ret_pc;
    assign ret_instr     = r_ret_instr;
    assign ret_seq       = r_ret_seq;
    assign count         = r_count;
    assign empty         = r_empty;
    assign full          = r_full;
    assign err_overflow  = r_err_overflow;
    assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_fv_commit_tracker.sv
// Randomised self-checking bench for fv_commit_tracker against a queue-based model.
module tb_fv_commit_tracker;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [7:0]  seq;
    } ent_t;

    logic        clk;
    logic        reset_;
    logic        issue_valid;
    logic [31:0] issue_pc;
    logic [31:0] issue_instr;
    logic        issue_stall;
    logic        kill;
    logic        commit;
    logic        ret_valid;
    logic [31:0] ret_pc;
    logic [31:0] ret_instr;
    logic [7:0]  ret_seq;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        err_overflow;
    logic        err_underflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    ent_t        m_q[$];
    logic [7:0]  m_seq;
    logic        m_ovf, m_unf, m_rv;
    logic [31:0] m_rpc, m_rinstr;
    logic [7:0]  m_rseq;

    fv_commit_tracker #(.DEPTH(DEPTH), .ADDR_W(32), .INSTR_W(32), .SEQ_W(8)) dut (
        .clk(clk), .reset_(reset_),
        .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_instr(issue_instr),
        .issue_stall(issue_stall), .kill(kill), .commit(commit),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_seq(ret_seq),
        .count(count), .empty(empty), .full(full),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_seq = 8'd0; m_ovf = 1'b0; m_unf = 1'b0; m_rv = 1'b0;
        m_rpc = 32'd0; m_rinstr = 32'd0; m_rseq = 8'd0;
    endtask

    // Drive one cycle of stimulus, advance the model, and return at posedge+1.
    task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic st, input logic kl, input logic cm);
        ent_t e;
        logic pop_ok;
        issue_valid = iv; issue_pc = pc; issue_instr = ins;
        issue_stall = st; kill = kl; commit = cm;
        pop_ok = cm && (m_q.size() != 0);
        if (cm && m_q.size() == 0) m_unf = 1'b1;
        m_rv = pop_ok;
        if (pop_ok) begin
            e = m_q.pop_front();
            m_rpc = e.pc; m_rinstr = e.instr; m_rseq = e.seq;
        end
        if (kl) begin
            m_q.delete();
        end else if (iv && !st) begin
            if (m_q.size() < DEPTH) begin
                e.pc = pc; e.instr = ins; e.seq = m_seq;
                m_q.push_back(e);
                m_seq = m_seq + 8'd1;
            end else begin
                m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        issue_valid = 1'b0; issue_stall = 1'b0; kill = 1'b0; commit = 1'b0;
    endtask

    // Asserts reset away from any clock edge and checks outputs before the next edge.
    task automatic test_reset(input string tag);
        reset_ = 1'b0;
        #2;
        n_checks++; if (ret_valid !== 1'b0) $display("FAIL %s ret_valid: got %0h expected 0", tag, ret_valid); else n_pass++;
        n_checks++; if (ret_pc !== 32'd0) $display("FAIL %s ret_pc: got %0h expected 0", tag, ret_pc); else n_pass++;
        n_checks++; if (ret_instr !== 32'd0) $display("FAIL %s ret_instr: got %0h expected 0", tag, ret_instr); else n_pass++;
        n_checks++; if (ret_seq !== 8'd0) $display("FAIL %s ret_seq: got %0h expected 0", tag, ret_seq); else n_pass++;
        n_checks++; if (count !== 4'd0) $display("FAIL %s count: got %0d expected 0", tag, count); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL %s empty: got %0h expected 1", tag, empty); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL %s full: got %0h expected 0", tag, full); else n_pass++;
        n_checks++; if (err_overflow !== 1'b0) $display("FAIL %s err_overflow: got %0h expected 0", tag, err_overflow); else n_pass++;
        n_checks++; if (err_underflow !== 1'b0) $display("FAIL %s err_underflow: got %0h expected 0", tag, err_underflow); else n_pass++;
        model_reset();
        reset_ = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h100 + 32'(4*i), $urandom, 1'b0, 1'b0, 1'b0);
        n_checks++; if (count !== 4'd3) $display("FAIL basic count: got %0d expected 3", count); else n_pass++;
        n_checks++; if (empty !== 1'b0) $display("FAIL basic empty: got %0h expected 0", empty); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            n_checks++; if (ret_valid !== 1'b1) $display("FAIL basic ret_valid[%0d]: got %0h expected 1", i, ret_valid); else n_pass++;
            n_checks++; if (ret_pc !== 32'h100 + 32'(4*i)) $display("FAIL basic ret_pc[%0d]: got %0h expected %0h", i, ret_pc, 32'h100 + 32'(4*i)); else n_pass++;
            n_checks++; if (ret_seq !== 8'(i)) $display("FAIL basic ret_seq[%0d]: got %0d expected %0d", i, ret_seq, i); else n_pass++;
            n_checks++; if (ret_instr !== m_rinstr) $display("FAIL basic ret_instr[%0d]: got %0h expected %0h", i, ret_instr, m_rinstr); else n_pass++;
        end
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (ret_valid !== 1'b0) $display("FAIL basic idle ret_valid: got %0h expected 0", ret_valid); else n_pass++;
        n_checks++; if (ret_pc !== 32'h108) $display("FAIL basic hold ret_pc: got %0h expected 108", ret_pc); else n_pass++;
        n_checks++; if (count !== 4'd0) $display("FAIL basic final count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL basic final empty: got %0h expected 1", empty); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h2000 + 32'(4*i), $urandom, 1'b0, 1'b0, 1'b0);
        n_checks++; if (full !== 1'b1) $display("FAIL ovf full: got %0h expected 1", full); else n_pass++;
        n_checks++; if (err_overflow !== 1'b0) $display("FAIL ovf early flag: got %0h expected 0", err_overflow); else n_pass++;
        cycle(1'b1, 32'hdead, $urandom, 1'b0, 1'b0, 1'b0);
        n_checks++; if (err_overflow !== 1'b1) $display("FAIL ovf flag: got %0h expected 1", err_overflow); else n_pass++;
        n_checks++; if (count !== 4'd8) $display("FAIL ovf count: got %0d expected 8", count); else n_pass++;
        cycle(1'b1, 32'h3000, $urandom, 1'b0, 1'b0, 1'b1);
        n_checks++; if (count !== 4'd8) $display("FAIL ovf pushpop count: got %0d expected 8", count); else n_pass++;
        n_checks++; if (ret_valid !== 1'b1 || ret_pc !== 32'h2000) $display("FAIL ovf pushpop ret: got v=%0h pc=%0h expected v=1 pc=2000", ret_valid, ret_pc); else n_pass++;
        n_checks++; if (ret_seq !== m_rseq) $display("FAIL ovf pushpop seq: got %0d expected %0d", ret_seq, m_rseq); else n_pass++;
        // Drain and make sure the accepted push landed behind the rest.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            n_checks++; if (ret_pc !== m_rpc) $display("FAIL ovf drain pc[%0d]: got %0h expected %0h", i, ret_pc, m_rpc); else n_pass++;
        end
        n_checks++; if (ret_pc !== 32'h3000) $display("FAIL ovf last pc: got %0h expected 3000", ret_pc); else n_pass++;
        n_checks++; if (err_overflow !== 1'b1) $display("FAIL ovf sticky: got %0h expected 1", err_overflow); else n_pass++;
    endtask

    task automatic test_underflow();
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (ret_valid !== 1'b0) $display("FAIL unf ret_valid: got %0h expected 0", ret_valid); else n_pass++;
        n_checks++; if (err_underflow !== 1'b1) $display("FAIL unf flag: got %0h expected 1", err_underflow); else n_pass++;
        // First push with a same-cycle commit is still an underflow (no bypass).
        cycle(1'b1, 32'h500, $urandom, 1'b0, 1'b0, 1'b1);
        n_checks++; if (ret_valid !== 1'b0 || count !== 4'd1) $display("FAIL unf nobypass: got v=%0h cnt=%0d expected v=0 cnt=1", ret_valid, count); else n_pass++;
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (err_underflow !== 1'b1) $display("FAIL unf sticky: got %0h expected 1", err_underflow); else n_pass++;
    endtask

    task automatic test_kill();
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h700 + 32'(4*i), $urandom, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hbad, $urandom, 1'b0, 1'b1, 1'b1);
        n_checks++; if (ret_valid !== 1'b1 || ret_pc !== 32'h700 || ret_seq !== 8'd0) $display("FAIL kill retire: got v=%0h pc=%0h seq=%0d expected v=1 pc=700 seq=0", ret_valid, ret_pc, ret_seq); else n_pass++;
        n_checks++; if (count !== 4'd0 || empty !== 1'b1) $display("FAIL kill count: got %0d empty=%0h expected 0 empty=1", count, empty); else n_pass++;
        cycle(1'b1, 32'h800, $urandom, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (ret_seq !== 8'd4 || ret_pc !== 32'h800) $display("FAIL kill next seq: got seq=%0d pc=%0h expected seq=4 pc=800", ret_seq, ret_pc); else n_pass++;
        n_checks++; if (err_underflow !== 1'b0) $display("FAIL kill no underflow: got %0h expected 0", err_underflow); else n_pass++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h900 + 32'(4*i), $urandom, 1'b1, 1'b0, 1'b0);
        n_checks++; if (count !== 4'd0) $display("FAIL stall count: got %0d expected 0", count); else n_pass++;
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h900 + 32'(4*i), $urandom, 1'b0, 1'b0, 1'b0);
        n_checks++; if (count !== 4'd3) $display("FAIL stall release count: got %0d expected 3", count); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            n_checks++; if (ret_pc !== 32'h900 + 32'(4*i)) $display("FAIL stall ret_pc[%0d]: got %0h expected %0h", i, ret_pc, 32'h900 + 32'(4*i)); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic saw_wrap;
        logic [7:0] prev;
        saw_wrap = 1'b0;
        prev = 8'd0;
        cycle(1'b1, 32'h4000, $urandom, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 300; i++) begin
            cycle(1'b1, 32'h4000 + 32'(4*i), $urandom, 1'b0, 1'b0, 1'b1);
            if (i > 1 && prev == 8'd255 && ret_seq == 8'd0) saw_wrap = 1'b1;
            prev = ret_seq;
            n_checks++;
            if (ret_valid !== 1'b1 || ret_pc !== m_rpc || ret_seq !== m_rseq || ret_instr !== m_rinstr || count !== 4'd1)
                $display("FAIL wrap[%0d]: got v=%0h pc=%0h seq=%0d cnt=%0d expected v=1 pc=%0h seq=%0d cnt=1", i, ret_valid, ret_pc, ret_seq, count, m_rpc, m_rseq);
            else n_pass++;
        end
        n_checks++; if (saw_wrap !== 1'b1) $display("FAIL wrap seq 255->0: got %0h expected 1", saw_wrap); else n_pass++;
    endtask

    task automatic test_random();
        logic iv, st, kl, cm;
        for (int i = 0; i < 600; i++) begin
            iv = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 7) == 0);
            kl = ($urandom_range(0, 40) == 0);
            cm = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle(iv, $urandom, $urandom, st, kl, cm);
            n_checks++;
            if (ret_valid !== m_rv || ret_pc !== m_rpc || ret_instr !== m_rinstr || ret_seq !== m_rseq)
                $display("FAIL rand ret[%0d]: got v=%0h pc=%0h seq=%0d expected v=%0h pc=%0h seq=%0d", i, ret_valid, ret_pc, ret_seq, m_rv, m_rpc, m_rseq);
            else n_pass++;
            n_checks++;
            if (count !== 4'(m_q.size()) || empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH))
                $display("FAIL rand occ[%0d]: got cnt=%0d e=%0h f=%0h expected cnt=%0d", i, count, empty, full, m_q.size());
            else n_pass++;
            n_checks++;
            if (err_overflow !== m_ovf || err_underflow !== m_unf)
                $display("FAIL rand err[%0d]: got ovf=%0h unf=%0h expected ovf=%0h unf=%0h", i, err_overflow, err_underflow, m_ovf, m_unf);
            else n_pass++;
        end
    endtask

    initial begin
        reset_ = 1'b0;
        issue_valid = 1'b0; issue_pc = '0; issue_instr = '0;
        issue_stall = 1'b0; kill = 1'b0; commit = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset("reset");
        test_basic();
        test_overflow();
        test_underflow();
        test_reset("reset2");
        test_kill();
        test_stall();
        test_reset("reset3");
        test_wrap();
        test_random();
        // Leave entries and sticky flags live, then reset between edges.
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h6000 + 32'(4*i), $urandom, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h6100, $urandom, 1'b0, 1'b0, 1'b1);
        test_reset("midstream");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fv_commit_tracker.md
Name: fv_commit_tracker

Overview:
- In-order tracking buffer that sits directly downstream of the fetch/issue stage in the formal harness.
- Records every instruction issued from IF to EX (PC, encoding, sequence tag) and retires entries in program order on core commit.
- Presents the retired instruction to the property/ARF checking logic one cycle after commit.
- Flags ordering violations: commit with nothing in flight, issue into a full buffer.

Parameters:
- DEPTH, 8, max in-flight instructions; power of two, >= 2
- ADDR_W, 32, PC width (matches FV instruction address width)
- INSTR_W, 32, instruction encoding width
- SEQ_W, 8, width of the wrapping issue sequence tag

Ports:
- clk  in  1  core clock
- reset_  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction issued IF->EX this cycle
- issue_pc  in  ADDR_W  PC of the issued instruction
- issue_instr  in  INSTR_W  encoding of the issued instruction
- issue_stall  in  1  IF2EX stall; blocks capture
- kill  in  1  pipeline kill/flush (IF2EX or EX kill)
- commit  in  1  oldest in-flight instruction commits this cycle
- ret_valid  out  1  registered: retired entry valid
- ret_pc  out  ADDR_W  PC of retired entry
- ret_instr  out  INSTR_W  encoding of retired entry
- ret_seq  out  SEQ_W  sequence tag of retired entry
- count  out  $clog2(DEPTH+1)  in-flight entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- err_overflow  out  1  sticky: push attempted while full with no pop
- err_underflow  out  1  sticky: commit while empty

Behaviour:
- Clock and reset: single clock clk. Reset reset_ is asynchronous, active-low.
- Reset values: all outputs 0 except empty = 1. Pointers, count and sequence counter are 0. Storage contents are don't-care. Reset mid-operation discards all entries immediately and clears the sticky errors.
- push = issue_valid & ~issue_stall & ~kill.
- pop = commit & ~empty.
- Push writes {issue_pc, issue_instr, seq_cnt} at wr_ptr, then increments wr_ptr and seq_cnt. seq_cnt wraps modulo 2^SEQ_W. Pointers wrap modulo DEPTH.
- Pop reads the entry at rd_ptr and increments rd_ptr. On the next cycle ret_valid = 1 and ret_pc/ret_instr/ret_seq show the popped entry. Latency is exactly 1 cycle; there is no back-pressure.
- If no pop occurs, ret_valid = 0 next cycle and ret_pc/ret_instr/ret_seq hold their last values.
- Count updates: push only +1; pop only -1; both or neither, unchanged.
- Push and pop in the same cycle are always legal, including when full (count stays DEPTH) and when count == 1.
- Empty-buffer bypass is not allowed: a commit in the same cycle as the first push while empty is an underflow.
- Underflow: commit & empty. No pop, ret_valid = 0 next cycle, err_underflow set (sticky until reset).
- Overflow: issue_valid & ~issue_stall & ~kill & full & ~commit. Push dropped, state unchanged, err_overflow set (sticky).
- Kill, applied in this order in the same cycle:
  1. A simultaneous pop completes normally and is reported next cycle.
  2. All remaining entries are discarded: wr_ptr <= rd_ptr (post-pop), count <= 0.
  3. Push is suppressed.
- seq_cnt is not rewound on kill, so tags after a flush stay unique within the window.
- kill & commit while empty: underflow is flagged and the flush is a no-op.

Test Plan:
- Reset then 3 pushes (PC 0x100, 0x104, 0x108; seq 0,1,2), no commit -> count = 3, empty = 0; 3 single commits -> ret_pc 0x100/0x104/0x108, ret_seq 0/1/2, each one cycle after its commit; count returns to 0, empty = 1.
- Fill to DEPTH = 8, then push without commit -> err_overflow = 1, count stays 8. Then push + commit in the same cycle -> count stays 8, oldest PC retired next cycle.
- commit while empty -> ret_valid = 0 next cycle, err_underflow = 1 and stays 1 until reset_ asserts.
- 4 in flight, kill + commit same cycle -> oldest entry retired next cycle, count = 0. The next push gets seq 4, not seq 0.
- issue_valid with issue_stall = 1 for 3 cycles -> no capture, count unchanged. Stall drops -> one capture per cycle of issue_valid.
- 300 push/commit pairs with SEQ_W = 8 -> ret_seq wraps 255 -> 0, and pointer wrap preserves order. Assert reset_ mid-stream -> all outputs return to reset values asynchronously, without waiting for a clk edge.
